// File: rtl/otter_crypto_engine.sv
// rtl/otter_crypto_engine.sv - iterative ARX cipher coprocessor with valid/ready handshakes
//
// Purpose: applies ROUNDS add-rotate-xor rounds to a WIDTH-bit word, encrypt or decrypt,
// one round per RUN cycle (two per cycle when OTTER_CRYPTO_UNROLL2_EN is defined).
// Ports:
//   CLK, RESET_N            clock, synchronous active-low reset
//   IN_VALID/IN_READY       request handshake; IN_DATA, IN_KEY, IN_DECRYPT sampled at acceptance
//   OUT_VALID/OUT_READY     result handshake; OUT_DATA held until the next result
//   BUSY                    high while rounds are being applied
//   ROUND                   round index being applied (first of the pair when unrolled), 0 otherwise
// Optional feature macro: OTTER_CRYPTO_UNROLL2_EN

module otter_crypto_engine #(
    parameter int WIDTH  = 32,
    parameter int ROUNDS = 4,
    parameter int ROT    = 5,
    localparam int RW    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic [WIDTH-1:0] IN_KEY,
    input  logic             IN_DECRYPT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             BUSY,
    output logic [RW-1:0]    ROUND
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] key_q;
    logic             mode_q;
    logic [RW-1:0]    r_q;
    logic [WIDTH-1:0] out_data_q;

    logic [WIDTH-1:0] x_one;
    logic [WIDTH-1:0] x_run;
    logic             last_one;
    logic             last_edge;
    logic [RW-1:0]    r_next;
    int unsigned      r_u;

    function automatic logic [WIDTH-1:0] rotl_n(input logic [WIDTH-1:0] v, input int unsigned n);
        int unsigned s;
        s = n % WIDTH;
        if (s == 0)
            return v;
        return (v << s) | (v >> (WIDTH - s));
    endfunction

    function automatic logic [WIDTH-1:0] enc_round(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] key,
                                                   input int unsigned r);
        logic [WIDTH-1:0] k;
        k = rotl_n(key, r);
        return rotl_n(x ^ k, ROT) + k;
    endfunction

    function automatic logic [WIDTH-1:0] dec_round(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] key,
                                                   input int unsigned r);
        logic [WIDTH-1:0] k;
        k = rotl_n(key, r);
        // rotr by ROT is rotl by WIDTH-ROT
        return rotl_n(x - k, WIDTH - ROT) ^ k;
    endfunction

    // Round datapath: one round at r, and for the unrolled build a second chained round at r+-1.
    always_comb begin
        r_u      = 32'(r_q);
        x_one    = '0;
        last_one = 1'b0;
        if (!mode_q) begin
            x_one    = enc_round(x_q, key_q, r_u);
            last_one = (r_q == RW'(ROUNDS - 1));
        end else begin
            x_one    = dec_round(x_q, key_q, r_u);
            last_one = (r_q == '0);
        end
    end

`ifdef OTTER_CRYPTO_UNROLL2_EN
    logic [WIDTH-1:0] x_two;

    always_comb begin
        x_two     = mode_q ? dec_round(x_one, key_q, r_u - 32'd1)
                           : enc_round(x_one, key_q, r_u + 32'd1);
        // With odd ROUNDS the final edge lands on a single remaining round.
        x_run     = last_one ? x_one : x_two;
        last_edge = mode_q ? (r_u <= 32'd1) : (r_u + 32'd2 >= 32'(ROUNDS));
        r_next    = mode_q ? (r_q - RW'(2)) : (r_q + RW'(2));
    end
`else
    always_comb begin
        x_run     = x_one;
        last_edge = last_one;
        r_next    = mode_q ? (r_q - RW'(1)) : (r_q + RW'(1));
    end
`endif

    always_ff @(posedge CLK) begin
        if (!RESET_N)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (IN_VALID)  state_d = RUN;
            RUN:     if (last_edge) state_d = DONE;
            DONE:    if (OUT_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            x_q        <= '0;
            key_q      <= '0;
            mode_q     <= 1'b0;
            r_q        <= '0;
            out_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (IN_VALID) begin
                        x_q    <= IN_DATA;
                        key_q  <= IN_KEY;
                        mode_q <= IN_DECRYPT;
                        r_q    <= IN_DECRYPT ? RW'(ROUNDS - 1) : '0;
                    end
                end
                RUN: begin
                    x_q <= x_run;
                    r_q <= r_next;
                    if (last_edge)
                        out_data_q <= x_run;
                end
                default: ;
            endcase
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign BUSY      = (state_q == RUN);
    assign ROUND     = (state_q == RUN) ? r_q : '0;
    assign OUT_DATA  = out_data_q;

endmodule
